// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared encodings for the msrv32 writeback stage
package msrv32_pkg;

    localparam logic [2:0] WB_SEL_ALU  = 3'd0;
    localparam logic [2:0] WB_SEL_LOAD = 3'd1;
    localparam logic [2:0] WB_SEL_CSR  = 3'd2;
    localparam logic [2:0] WB_SEL_PC4  = 3'd3;
    localparam logic [2:0] WB_SEL_IMM  = 3'd4;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/msrv32_load_align.sv
// rtl/msrv32_load_align.sv - byte/half lane select and sign/zero extension of load data
module msrv32_load_align
    import msrv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = data_i[{offset_i, 3'b000} +: 8];
        // halfword lanes are picked by offset[1] only; offset[0] is ignored
        half_w = data_i[{offset_i[1], 4'b0000} +: 16];
        case (funct3_i)
            FUNCT3_LB:  result_o = {{(XLEN-8){byte_w[7]}}, byte_w};
            FUNCT3_LBU: result_o = {{(XLEN-8){1'b0}}, byte_w};
            FUNCT3_LH:  result_o = {{(XLEN-16){half_w[15]}}, half_w};
            FUNCT3_LHU: result_o = {{(XLEN-16){1'b0}}, half_w};
            default:    result_o = data_i;
        endcase
    end

endmodule

// File: rtl/msrv32_writeback_unit.sv
// rtl/msrv32_writeback_unit.sv - result select, load wait FSM with timeout, register file write port
module msrv32_writeback_unit
    import msrv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TMO_W = 4
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic            valid_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            rf_wr_en_in,
    input  logic [2:0]      wb_sel_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] csr_data_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [2:0]      load_funct3_in,
    input  logic [XLEN-1:0] dmem_rdata_in,
    input  logic            dmem_rvalid_in,
    output logic [4:0]      rd_addr_out,
    output logic            wr_en_out,
    output logic [XLEN-1:0] rd_out,
    output logic            stall_out,
    output logic            load_fault_out
);

    // Last counter value still waiting; the step past it is the timeout.
    localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    wb_state_e         state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        cap_rd_q, cap_rd_d;
    logic              cap_wen_q, cap_wen_d;
    logic [2:0]        cap_f3_q, cap_f3_d;
    logic [1:0]        cap_off_q, cap_off_d;
    logic              wr_en_q, wr_en_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   sel_data;
    logic [XLEN-1:0]   load_data;

    msrv32_load_align #(.XLEN(XLEN)) u_load_align (
        .data_i   (dmem_rdata_in),
        .offset_i (cap_off_q),
        .funct3_i (cap_f3_q),
        .result_o (load_data)
    );

    always_comb begin
        case (wb_sel_in)
            WB_SEL_ALU: sel_data = alu_result_in;
            WB_SEL_CSR: sel_data = csr_data_in;
            WB_SEL_PC4: sel_data = pc_plus4_in;
            WB_SEL_IMM: sel_data = imm_in;
            default:    sel_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_rd_d  = cap_rd_q;
        cap_wen_d = cap_wen_q;
        cap_f3_d  = cap_f3_q;
        cap_off_d = cap_off_q;
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_d      = rd_q;
        fault_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (wb_sel_in == WB_SEL_LOAD) begin
                        cap_rd_d  = rd_addr_in;
                        cap_wen_d = rf_wr_en_in;
                        cap_f3_d  = load_funct3_in;
                        cap_off_d = alu_result_in[1:0];
                        cnt_d     = '0;
                        state_d   = ST_WAIT_LOAD;
                    end else begin
                        wr_en_d   = rf_wr_en_in & (rd_addr_in != 5'd0);
                        rd_addr_d = rd_addr_in;
                        rd_d      = sel_data;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                cnt_d = cnt_q + 1'b1;
                // data arriving on the final wait cycle still beats the timeout
                if (dmem_rvalid_in) begin
                    wr_en_d   = cap_wen_q & (cap_rd_q != 5'd0);
                    rd_addr_d = cap_rd_q;
                    rd_d      = load_data;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cap_rd_q  <= '0;
            cap_wen_q <= 1'b0;
            cap_f3_q  <= '0;
            cap_off_q <= '0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_q      <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_rd_q  <= cap_rd_d;
            cap_wen_q <= cap_wen_d;
            cap_f3_q  <= cap_f3_d;
            cap_off_q <= cap_off_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
            fault_q   <= fault_d;
        end
    end

    assign stall_out      = (state_q == ST_WAIT_LOAD);
    assign wr_en_out      = wr_en_q;
    assign rd_addr_out    = rd_addr_q;
    assign rd_out         = rd_q;
    assign load_fault_out = fault_q;

endmodule
